// File: rtl/tick_bcd_timer.sv
// rtl/tick_bcd_timer.sv - MM:SS BCD up/down timer stepped by rising edges of the divider tick level
// Optional alarm compare port pair is built only when TICK_BCD_TIMER_ALARM_EN is defined.
module tick_bcd_timer #(
    parameter int TICKS_PER_STEP = 1,
    parameter int PRESCALE_W     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_in,
    input  logic        start_stop,
    input  logic        load,
    input  logic [15:0] preset,
    input  logic        dir,
`ifdef TICK_BCD_TIMER_ALARM_EN
    input  logic [15:0] alarm_val,
    output logic        alarm_hit,
`endif
    output logic [15:0] digits,
    output logic        running,
    output logic        done,
    output logic        div_start
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    localparam logic [PRESCALE_W-1:0] LP_LAST = PRESCALE_W'(TICKS_PER_STEP - 1);
    localparam logic [15:0]           LP_TOP  = 16'h9959;

    state_t                r_state, w_state_nxt;
    logic [15:0]           r_digits, w_digits_nxt, w_step_val, w_load_val;
    logic [PRESCALE_W-1:0] r_prescale, w_prescale_nxt;
    logic                  r_tick_q, r_running, r_done;
    logic                  w_rise, w_terminal;

    function automatic logic [3:0] clamp_nib(input logic [3:0] n, input logic [3:0] lim);
        return (n > lim) ? lim : n;
    endfunction

    function automatic logic [15:0] bcd_up(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd9) r[3:0] = v[3:0] + 4'd1;
        else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd5) r[7:4] = v[7:4] + 4'd1;
            else begin
                r[7:4] = 4'd0;
                if (v[11:8] != 4'd9) r[11:8] = v[11:8] + 4'd1;
                else begin
                    r[11:8]  = 4'd0;
                    r[15:12] = (v[15:12] == 4'd9) ? 4'd0 : v[15:12] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_down(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd0) r[3:0] = v[3:0] - 4'd1;
        else begin
            r[3:0] = 4'd9;
            if (v[7:4] != 4'd0) r[7:4] = v[7:4] - 4'd1;
            else begin
                r[7:4] = 4'd5;
                if (v[11:8] != 4'd0) r[11:8] = v[11:8] - 4'd1;
                else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = (v[15:12] == 4'd0) ? 4'd9 : v[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign w_rise     = tick_in & ~r_tick_q;
    assign w_terminal = dir ? (r_digits == LP_TOP) : (r_digits == 16'h0000);
    assign w_step_val = dir ? bcd_up(r_digits) : bcd_down(r_digits);
    assign w_load_val = {clamp_nib(preset[15:12], 4'd9), clamp_nib(preset[11:8], 4'd9),
                         clamp_nib(preset[7:4], 4'd5),   clamp_nib(preset[3:0], 4'd9)};

`ifdef TICK_BCD_TIMER_ALARM_EN
    logic w_step;
    logic r_alarm_hit;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_digits_nxt   = r_digits;
        w_prescale_nxt = r_prescale;
`ifdef TICK_BCD_TIMER_ALARM_EN
        w_step         = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_digits_nxt   = w_load_val;
                    w_prescale_nxt = '0;
                end else if (start_stop) begin
                    if (w_terminal) w_state_nxt = S_DONE;
                    else begin
                        w_state_nxt    = S_RUN;
                        w_prescale_nxt = '0;
                    end
                end
            end
            S_RUN: begin
                // a pause request drops any coincident step without advancing prescale
                if (start_stop) w_state_nxt = S_PAUSE;
                else if (w_rise) begin
                    if (r_prescale == LP_LAST) begin
                        w_prescale_nxt = '0;
                        w_digits_nxt   = w_step_val;
`ifdef TICK_BCD_TIMER_ALARM_EN
                        w_step         = 1'b1;
`endif
                        if (w_step_val == (dir ? LP_TOP : 16'h0000)) w_state_nxt = S_DONE;
                    end else begin
                        w_prescale_nxt = r_prescale + PRESCALE_W'(1);
                    end
                end
            end
            S_PAUSE: begin
                if (load) begin
                    w_state_nxt    = S_IDLE;
                    w_digits_nxt   = w_load_val;
                    w_prescale_nxt = '0;
                end else if (start_stop) begin
                    w_state_nxt = w_terminal ? S_DONE : S_RUN;
                end
            end
            S_DONE: begin
                if (load) begin
                    w_state_nxt    = S_IDLE;
                    w_digits_nxt   = w_load_val;
                    w_prescale_nxt = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // tick_q idles high so a divider that starts high never looks like a fresh edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_digits   <= 16'h0000;
            r_prescale <= '0;
            r_tick_q   <= 1'b1;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_digits   <= w_digits_nxt;
            r_prescale <= w_prescale_nxt;
            r_tick_q   <= tick_in;
            r_running  <= (w_state_nxt == S_RUN);
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

`ifdef TICK_BCD_TIMER_ALARM_EN
    always_ff @(posedge clk) begin
        if (reset) r_alarm_hit <= 1'b0;
        else       r_alarm_hit <= w_step && (w_step_val == alarm_val);
    end
    assign alarm_hit = r_alarm_hit;
`endif

    assign digits    = r_digits;
    assign running   = r_running;
    assign done      = r_done;
    assign div_start = r_running;
endmodule

// File: tb/tb_tick_bcd_timer.sv
// tb/tb_tick_bcd_timer.sv - scoreboard bench for tick_bcd_timer at TICKS_PER_STEP 1 and 3
module tb_tick_bcd_timer;
    typedef struct packed {
        logic [15:0] dg;
        logic        ru;
        logic        dn;
        logic        ds;
        logic        ah;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1, tick_in = 1'b1, start_stop = 1'b0, load = 1'b0, dir = 1'b0;
    logic [15:0] preset = 16'h0000, alarm_val = 16'h0003;
    logic [15:0] dg1, dg3;
    logic        ru1, ru3, dn1, dn3, ds1, ds3, ah1, ah3;

    int   total = 0, bad = 0;
    exp_t q0[$], q1[$];
    int   t[2], st[2], pc[2];
    int   tps[2] = '{1, 3};
    bit   tq = 1'b1;
    bit   cur_tk = 1'b1, cur_d = 1'b0;

    always #5 clk = ~clk;

    tick_bcd_timer #(.TICKS_PER_STEP(1), .PRESCALE_W(8)) u_t1 (
        .clk(clk), .reset(reset), .tick_in(tick_in), .start_stop(start_stop), .load(load),
        .preset(preset), .dir(dir),
`ifdef TICK_BCD_TIMER_ALARM_EN
        .alarm_val(alarm_val), .alarm_hit(ah1),
`endif
        .digits(dg1), .running(ru1), .done(dn1), .div_start(ds1));

    tick_bcd_timer #(.TICKS_PER_STEP(3), .PRESCALE_W(8)) u_t3 (
        .clk(clk), .reset(reset), .tick_in(tick_in), .start_stop(start_stop), .load(load),
        .preset(preset), .dir(dir),
`ifdef TICK_BCD_TIMER_ALARM_EN
        .alarm_val(alarm_val), .alarm_hit(ah3),
`endif
        .digits(dg3), .running(ru3), .done(dn3), .div_start(ds3));

`ifndef TICK_BCD_TIMER_ALARM_EN
    assign ah1 = 1'b0;
    assign ah3 = 1'b0;
`endif

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Reference works in whole seconds 0..5999; BCD only at the edges.
    function automatic int to_sec(input logic [15:0] p);
        int mt, mo, sti, so;
        mt = min_i(int'(p[15:12]), 9); mo = min_i(int'(p[11:8]), 9);
        sti = min_i(int'(p[7:4]), 5);  so = min_i(int'(p[3:0]), 9);
        return (mt * 10 + mo) * 60 + sti * 10 + so;
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int m, ss;
        m = s / 60; ss = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic cyc(input bit r, input bit tk, input bit ss, input bit ld,
                       input logic [15:0] pv, input bit d, input logic [15:0] av);
        bit   rise, term, hit;
        exp_t e;
        @(negedge clk);
        reset = r; tick_in = tk; start_stop = ss; load = ld; preset = pv; dir = d; alarm_val = av;
        rise = tk && !tq;
        for (int k = 0; k < 2; k++) begin
            hit = 1'b0;
            if (r) begin
                t[k] = 0; st[k] = 0; pc[k] = 0;
            end else begin
                term = d ? (t[k] == 5999) : (t[k] == 0);
                case (st[k])
                    0: if (ld) begin t[k] = to_sec(pv); pc[k] = 0; end
                       else if (ss) begin
                           if (term) st[k] = 3;
                           else begin st[k] = 1; pc[k] = 0; end
                       end
                    1: if (ss) st[k] = 2;
                       else if (rise) begin
                           if (pc[k] == tps[k] - 1) begin
                               pc[k] = 0;
                               t[k] = d ? (t[k] + 1) % 6000 : (t[k] + 5999) % 6000;
                               hit = (to_bcd(t[k]) == av);
                               if (t[k] == (d ? 5999 : 0)) st[k] = 3;
                           end else pc[k]++;
                       end
                    2: if (ld) begin t[k] = to_sec(pv); pc[k] = 0; st[k] = 0; end
                       else if (ss) st[k] = term ? 3 : 1;
                    default: if (ld) begin t[k] = to_sec(pv); pc[k] = 0; st[k] = 0; end
                endcase
            end
            e.dg = to_bcd(t[k]); e.ru = (st[k] == 1); e.dn = (st[k] == 3);
            e.ds = (st[k] == 1); e.ah = hit;
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
        tq = r ? 1'b1 : tk;
    endtask

    task automatic chk(input string nm, input int k, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s tps%0d got=%h want=%h", nm, k, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("digits", 1, dg1, e.dg);
                chk("running", 1, 16'(ru1), 16'(e.ru));
                chk("done", 1, 16'(dn1), 16'(e.dn));
                chk("div_start", 1, 16'(ds1), 16'(e.ds));
`ifdef TICK_BCD_TIMER_ALARM_EN
                chk("alarm_hit", 1, 16'(ah1), 16'(e.ah));
`endif
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("digits", 3, dg3, e.dg);
                chk("running", 3, 16'(ru3), 16'(e.ru));
                chk("done", 3, 16'(dn3), 16'(e.dn));
                chk("div_start", 3, 16'(ds3), 16'(e.ds));
`ifdef TICK_BCD_TIMER_ALARM_EN
                chk("alarm_hit", 3, 16'(ah3), 16'(e.ah));
`endif
            end
        end
    end

    initial begin : stim
        logic [15:0] pv, av;
        bit          r, ss, ld;
        cyc(1, 1, 0, 0, 16'h0000, 0, 16'h0003);
        cyc(1, 1, 0, 0, 16'h0000, 0, 16'h0003);
        cyc(0, 1, 0, 1, 16'h0058, 1, 16'h0003);
        cyc(0, 1, 1, 0, 16'h0000, 1, 16'h0003);
        for (int i = 0; i < 6; i++) cyc(0, i[0], 0, 0, 16'h0000, 1, 16'h0003);
        cyc(0, 0, 0, 1, 16'h0000, 1, 16'h0003);
        cyc(0, 1, 1, 0, 16'h0000, 1, 16'h0003);
        for (int i = 0; i < 4; i++) cyc(0, i[0], 0, 0, 16'h0000, 1, 16'h0003);
        cyc(0, 0, 1, 0, 16'h0000, 1, 16'h0003);
        for (int i = 0; i < 4; i++) cyc(0, i[0], 0, 0, 16'h0000, 1, 16'h0003);
        cyc(1, 1, 0, 0, 16'h0000, 1, 16'h0003);
        cyc(0, 1, 0, 1, 16'h0001, 0, 16'h0003);
        cyc(0, 1, 1, 0, 16'h0000, 0, 16'h0003);
        for (int i = 0; i < 8; i++) cyc(0, i[0], 0, 0, 16'h0000, 0, 16'h0003);
        cyc(0, 0, 1, 0, 16'h0000, 0, 16'h0003);
        cyc(0, 0, 0, 1, 16'h9959, 1, 16'h0003);
        cyc(0, 0, 1, 0, 16'h0000, 1, 16'h0003);
        cyc(0, 0, 0, 1, 16'hAB7C, 1, 16'h0003);
        cyc(0, 0, 0, 1, 16'h0000, 1, 16'h0003);
        cyc(0, 0, 1, 0, 16'h0000, 1, 16'h0003);
        for (int i = 0; i < 24; i++) cyc(0, i[0], 0, 0, 16'h0000, 1, 16'h0003);
        cyc(0, 0, 1, 0, 16'h0000, 1, 16'h0003);
        cyc(0, 0, 0, 1, 16'h0003, 1, 16'h0003);
        cyc(0, 1, 0, 0, 16'h0000, 1, 16'h0003);
        cur_tk = 1'b1;
        av = 16'h0003;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 2) == 0) cur_tk = ~cur_tk;
            if ($urandom_range(0, 99) == 0) cur_d = ~cur_d;
            ss = ($urandom_range(0, 29) == 0);
            ld = ($urandom_range(0, 49) == 0);
            r  = ($urandom_range(0, 1999) == 0);
            case ($urandom_range(0, 3))
                0: pv = 16'($urandom);
                1: pv = {8'h00, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
                2: pv = {8'h99, 4'h5, 4'($urandom_range(0, 9))};
                default: pv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 8'h00};
            endcase
            if (ld) av = to_bcd(int'($urandom_range(0, 5999)));
            cyc(r, cur_tk, ss, ld, pv, cur_d, av);
        end
        repeat (3) @(negedge clk);
        total++;
        if (q0.size() + q1.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", q0.size() + q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
